// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel-stream sink.
// Frame geometry constants live elsewhere; this package only holds stream-sink definitions.
package vga_pkg;

   typedef enum logic [1:0] {
      RESYNC     = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2
   } vga_ps_state_t;

   // Level counter needs one extra bit so that "full" is distinct from "empty".
   function automatic int unsigned ps_level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rdata whenever empty is low.
// Flush has priority over push and pop in the same cycle.
module vga_pixel_fifo
   import vga_pkg::*;
#(
   parameter int unsigned WIDTH = 13,
   parameter int unsigned DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              wdata,
   input  logic                          pop,
   input  logic                          flush,
   output logic [WIDTH-1:0]              rdata,
   output logic                          full,
   output logic                          empty,
   output logic [ps_level_w(DEPTH)-1:0]  level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = ps_level_w(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/vga_pixel_stream.sv
// Pixel-stream sink behind vga_sync: buffers source pixels, emits one per video_on cycle,
// re-times syncs by one cycle and relocks to frame boundaries after underflow or misalignment.
module vga_pixel_stream
   import vga_pkg::*;
#(
   parameter int unsigned RGB_W      = 12,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst_n,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic             src_sof,
   input  logic [RGB_W-1:0] src_rgb,
   input  logic             sync_hsync,
   input  logic             sync_vsync,
   input  logic             sync_video_on,
   input  logic             sync_scan_end,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             locked,
   input  logic             err_clr,
   output logic             underflow,
   output logic             align_err
);

   localparam int unsigned LW = ps_level_w(FIFO_DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   vga_ps_state_t  state;
   logic           first;
   logic [RGB_W:0] fifo_wdata;
   logic [RGB_W:0] fifo_rdata;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_flush;
   logic           fifo_full;
   logic           fifo_empty;
   logic [LW-1:0]  fifo_level;
   logic           accept;
   logic           chk;
   logic           uf_hit;
   logic           al_hit;
   logic           px_ok;
   logic           head_sof;
   logic           fill_next;

   assign accept     = src_valid & src_ready;
   assign head_sof   = fifo_rdata[RGB_W];
   assign chk        = (state == ACTIVE) & sync_video_on;
   assign uf_hit     = chk & fifo_empty;
   assign al_hit     = chk & ~fifo_empty & (head_sof != first);
   assign px_ok      = chk & ~fifo_empty & (head_sof == first);
   assign fifo_wdata = {src_sof, src_rgb};
   // While resyncing, only a start-of-frame beat may enter the FIFO.
   assign fifo_push  = accept & ((state != RESYNC) | src_sof);
   assign fifo_pop   = chk & ~fifo_empty;
   assign fifo_flush = uf_hit | al_hit;

   // src_ready is registered, so it is derived from the level the FIFO will hold next cycle.
   assign fill_next = ~fifo_flush &
                      ((fifo_full & ~fifo_pop) |
                       ((fifo_level == FULL_LVL - 1'b1) & fifo_push & ~fifo_pop));

   vga_pixel_fifo #(
      .WIDTH (RGB_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (pixel_clk),
      .rst_n (pixel_rst_n),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         state     <= RESYNC;
         first     <= 1'b0;
         src_ready <= 1'b0;
         locked    <= 1'b0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         vga_rgb   <= '0;
         underflow <= 1'b0;
         align_err <= 1'b0;
      end else begin
         vga_hsync <= sync_hsync;
         vga_vsync <= sync_vsync;
         vga_rgb   <= px_ok ? fifo_rdata[RGB_W-1:0] : '0;
         underflow <= uf_hit | (underflow & ~err_clr);
         align_err <= al_hit | (align_err & ~err_clr);

         case (state)
            RESYNC: begin
               locked <= 1'b0;
               if (accept & src_sof) begin
                  state     <= WAIT_FRAME;
                  src_ready <= ~fill_next;
               end else begin
                  src_ready <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               src_ready <= ~fill_next;
               if (sync_scan_end) begin
                  state  <= ACTIVE;
                  first  <= 1'b1;
                  locked <= 1'b1;
               end else begin
                  locked <= 1'b0;
               end
            end
            ACTIVE: begin
               // Deassert ready on the way out so nothing is accepted into a FIFO being discarded.
               if (fifo_flush) begin
                  state     <= RESYNC;
                  src_ready <= 1'b0;
                  locked    <= 1'b0;
               end else begin
                  src_ready <= ~fill_next;
                  locked    <= 1'b1;
                  if (sync_scan_end) begin
                     first <= 1'b1;
                  end else if (px_ok) begin
                     first <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= RESYNC;
               src_ready <= 1'b0;
               locked    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Scoreboard bench for vga_pixel_stream using a reduced frame geometry (128x4 visible).
// The driver pushes expected outputs per cycle; a separate monitor pops and compares.
module tb_vga_pixel_stream;

   localparam int H_DISPLAY = 128;
   localparam int H_FP      = 8;
   localparam int H_SYNC    = 16;
   localparam int H_BP      = 8;
   localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_DISPLAY = 4;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 1;
   localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int FRAME_PX  = H_DISPLAY * V_DISPLAY;
   localparam int RGB_W     = 12;
   localparam int DEPTH     = 16;

   logic             pixel_clk     = 1'b0;
   logic             pixel_rst_n   = 1'b0;
   logic             src_valid     = 1'b0;
   logic             src_ready;
   logic             src_sof       = 1'b0;
   logic [RGB_W-1:0] src_rgb       = '0;
   logic             sync_hsync    = 1'b1;
   logic             sync_vsync    = 1'b1;
   logic             sync_video_on = 1'b0;
   logic             sync_scan_end = 1'b0;
   logic             vga_hsync;
   logic             vga_vsync;
   logic [RGB_W-1:0] vga_rgb;
   logic             locked;
   logic             err_clr       = 1'b0;
   logic             underflow;
   logic             align_err;

   vga_pixel_stream #(
      .RGB_W      (RGB_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .pixel_clk     (pixel_clk),
      .pixel_rst_n   (pixel_rst_n),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .src_sof       (src_sof),
      .src_rgb       (src_rgb),
      .sync_hsync    (sync_hsync),
      .sync_vsync    (sync_vsync),
      .sync_video_on (sync_video_on),
      .sync_scan_end (sync_scan_end),
      .vga_hsync     (vga_hsync),
      .vga_vsync     (vga_vsync),
      .vga_rgb       (vga_rgb),
      .locked        (locked),
      .err_clr       (err_clr),
      .underflow     (underflow),
      .align_err     (align_err)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      int               f;
      int               v;
      int               h;
      logic [RGB_W+1:0] out;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Pixels with index below the cut are shown; frame 0 is black while locking,
   // frame 3 underflows at line 1 pixel 35, frame 5 misaligns at line 2 pixel 100.
   int cut_tbl [8] = '{0, FRAME_PX, FRAME_PX, 163, FRAME_PX, 356, FRAME_PX, FRAME_PX};

   bit run         = 1'b0;
   int nh          = 0;
   int nv          = 0;
   int nframe      = 0;
   int cur_h       = 0;
   int cur_v       = 0;
   int frame_no    = 0;
   int junk_left   = 3;
   int src_px      = 0;
   int stall_cnt   = 0;
   bit inj_pending = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic drive_cycle();
      int   px;
      int   cut;
      logic von;
      exp_t e;
      cur_h    = nh;
      cur_v    = nv;
      frame_no = nframe;
      if (nh == H_TOTAL - 1) begin
         nh = 0;
         if (nv == V_TOTAL - 1) begin
            nv = 0;
            nframe++;
         end else begin
            nv++;
         end
      end else begin
         nh++;
      end

      von           = (cur_h < H_DISPLAY) && (cur_v < V_DISPLAY);
      sync_video_on = von;
      sync_hsync    = !((cur_h >= H_DISPLAY + H_FP) && (cur_h < H_DISPLAY + H_FP + H_SYNC));
      sync_vsync    = !((cur_v >= V_DISPLAY + V_FP) && (cur_v < V_DISPLAY + V_FP + V_SYNC));
      sync_scan_end = (cur_h == H_TOTAL - 1) && (cur_v == V_TOTAL - 1);

      if (frame_no == 3 && cur_v == 1 && cur_h == 20) stall_cnt = 20;
      if (junk_left > 0) begin
         src_valid = 1'b1;
         src_sof   = 1'b0;
         src_rgb   = 12'hABC;
      end else if (stall_cnt > 0) begin
         src_valid = 1'b0;
         stall_cnt--;
      end else begin
         src_valid = 1'b1;
         src_sof   = (src_px == 0) || (inj_pending && src_px == 356);
         src_rgb   = RGB_W'(src_px);
      end
      if (src_valid && src_ready) begin
         if (junk_left > 0) begin
            junk_left--;
         end else begin
            if (inj_pending && src_px == 356) inj_pending = 1'b0;
            src_px = (src_px + 1) % FRAME_PX;
         end
      end

      px    = cur_v * H_DISPLAY + cur_h;
      cut   = (frame_no < 8) ? cut_tbl[frame_no] : FRAME_PX;
      e.f   = frame_no;
      e.v   = cur_v;
      e.h   = cur_h;
      e.out = {!((cur_h >= H_DISPLAY + H_FP) && (cur_h < H_DISPLAY + H_FP + H_SYNC)),
               !((cur_v >= V_DISPLAY + V_FP) && (cur_v < V_DISPLAY + V_FP + V_SYNC)),
               (von && px < cut) ? RGB_W'(px) : RGB_W'(0)};
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(negedge pixel_clk);
      if (run) drive_cycle();
   end

   // Monitor: one output beat per cycle, compared {hsync, vsync, rgb}.
   initial forever begin
      exp_t e;
      @(posedge pixel_clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check($sformatf("out f%0d v%0d h%0d", e.f, e.v, e.h),
               {vga_hsync, vga_vsync, vga_rgb}, e.out);
      end
   end

   task automatic wait_pos(input int f, input int v, input int h);
      int n;
      n = 0;
      do begin
         @(posedge pixel_clk);
         #1;
         n++;
      end while (!(frame_no == f && cur_v == v && cur_h == h) && n < 20000);
      if (!(frame_no == f && cur_v == v && cur_h == h)) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_pos: got f%0d v%0d h%0d, expected f%0d v%0d h%0d",
                  frame_no, cur_v, cur_h, f, v, h);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_hsync"},     vga_hsync, 1);
      check({tag, "_vsync"},     vga_vsync, 1);
      check({tag, "_rgb"},       vga_rgb,   0);
      check({tag, "_ready"},     src_ready, 0);
      check({tag, "_locked"},    locked,    0);
      check({tag, "_underflow"}, underflow, 0);
      check({tag, "_align_err"}, align_err, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge pixel_clk);
      #1;
      check_reset_vals("por");
      #1;
      pixel_rst_n = 1'b1;
      run         = 1'b1;
      @(posedge pixel_clk);
      #1;
      check("ready_rise", src_ready, 1);

      // Lock: locked rises right after the scan_end cycle of frame 0.
      wait_pos(0, V_TOTAL - 1, H_TOTAL - 2);
      check("pre_lock", locked, 0);
      wait_pos(0, V_TOTAL - 1, H_TOTAL - 1);
      check("lock_after_scan_end", locked, 1);

      // Backpressure during vertical blanking: next frame's first 16 beats buffered.
      wait_pos(1, 6, 0);
      check("bp_ready_low", src_ready, 0);
      check("bp_buffered",  src_px, 16);
      check("bp_no_err",    {underflow, align_err}, 0);

      // Underflow: source stalls at line 1 pixel 20 of frame 3.
      n = 0;
      do begin
         @(posedge pixel_clk);
         #1;
         n++;
      end while (underflow !== 1'b1 && n < 5000);
      check("uf_seen",   underflow, 1);
      check("uf_pos",    cur_v * H_TOTAL + cur_h, 1 * H_TOTAL + 35);
      check("uf_rgb",    vga_rgb, 0);
      check("uf_locked", locked, 0);
      wait_pos(3, V_TOTAL - 1, H_TOTAL - 1);
      check("uf_relock", locked, 1);

      wait_pos(4, 0, 10);
      check("uf_sticky", underflow, 1);
      err_clr = 1'b1;
      @(posedge pixel_clk);
      #1;
      err_clr = 1'b0;
      check("clr_underflow", underflow, 0);
      check("clr_align",     align_err, 0);

      // Misalignment: sof injected on line 2 pixel 100 of frame 5.
      wait_pos(5, 0, 0);
      inj_pending = 1'b1;
      n = 0;
      do begin
         @(posedge pixel_clk);
         #1;
         n++;
      end while (align_err !== 1'b1 && n < 5000);
      check("al_seen",   align_err, 1);
      check("al_pos",    cur_v * H_TOTAL + cur_h, 2 * H_TOTAL + 100);
      check("al_rgb",    vga_rgb, 0);
      check("al_locked", locked, 0);
      check("al_no_uf",  underflow, 0);
      wait_pos(5, V_TOTAL - 1, H_TOTAL - 1);
      check("al_relock", locked, 1);
      check("al_sticky", align_err, 1);

      // Asynchronous reset mid-frame, inside the hsync pulse of line 2.
      wait_pos(7, 2, 139);
      run = 1'b0;
      @(negedge pixel_clk);
      #2;
      check("pre_rst_hsync",  vga_hsync, 0);
      check("pre_rst_locked", locked, 1);
      pixel_rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(posedge pixel_clk);
      #2;
      pixel_rst_n = 1'b1;
      #1;
      check("ready_before_edge", src_ready, 0);
      @(posedge pixel_clk);
      #1;
      check("ready_after_edge", src_ready, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout, expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
